// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-backed UART transmitter:
// FSM state encoding, parity modes and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Narrower payloads are zero-extended by the caller; zeros do not disturb the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side valid/ready handshake between the CPU store path and the TX FIFO.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid_i;
  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_ready_o;

  modport master (output tx_valid_i, output tx_data_i, input  tx_ready_o);
  modport slave  (input  tx_valid_i, input  tx_data_i, output tx_ready_o);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full/empty come from the occupancy count and a push
// while full is refused even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign wr_ptr_d = wr_ptr_q + PW'(do_push);
  assign rd_ptr_d = rd_ptr_q + PW'(do_pop);
  assign count_d  = count_q + CW'(do_push) - CW'(do_pop);

  // NOTE: storage is not reset; only pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Configurable UART transmitter fed from a TX FIFO; bit timing comes from a
// fractional BAUD/CLK_HZ accumulator that restarts at every frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 10000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sys_clk_i,
  input  logic                        sys_rstn_i,
  uart_tx_fifo_if.slave               wr,
  input  logic                        tx_enable_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        tx_busy_o,
  output logic                        uart_tx_o
);

  localparam int          AW        = $clog2(CLK_HZ) + 1;
  localparam logic [AW:0] CLK_W     = (AW+1)'(CLK_HZ);
  localparam logic [AW:0] BAUD_W    = (AW+1)'(BAUD);
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;

  logic [AW:0]          sum;
  logic                 tick;
  logic                 can_start;
  logic                 start_frame;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk_i),
    .rst_n (sys_rstn_i),
    .push  (wr.tx_valid_i),
    .pop   (fifo_pop),
    .wdata (wr.tx_data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_o)
  );

  assign wr.tx_ready_o = ~fifo_full;
  assign sum           = {1'b0, acc_q} + BAUD_W;
  assign tick          = (sum >= CLK_W);
  assign can_start     = ~fifo_empty & tx_enable_i;
  assign tx_busy_o     = (state_q != ST_IDLE);
  assign uart_tx_o     = tx_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
    acc_d       = tick ? AW'(sum - CLK_W) : sum[AW-1:0];

    unique case (state_q)
      ST_IDLE: begin
        acc_d       = '0;
        tx_d        = 1'b1;
        start_frame = can_start;
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d   = ST_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt_q != LAST_STOP) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (can_start) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Starting from IDLE or straight out of the last stop bit share one path,
    // so back-to-back frames get the same nominal first-bit length.
    if (start_frame) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_rdata;
      par_d     = parity_bit(8'(fifo_rdata), PARITY);
      bit_cnt_d = '0;
      acc_d     = '0;
      tx_d      = 1'b0;
      state_d   = ST_START;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rstn_i) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four 16-cycle-per-bit instances (8N1, 8E1, 8O1, 7N2)
// plus one at the default 10 MHz / 115200 rate, checked against a frame scoreboard.
module tb_uart_tx_fifo;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en_main;
  logic en_on;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8)) if_8n1 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_8e1 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_8o1 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if_7n2 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_def ();

  logic [4:0] cnt_8n1, cnt_8e1, cnt_8o1, cnt_7n2;
  logic [2:0] cnt_def;
  logic       tx_8n1, tx_8e1, tx_8o1, tx_7n2, tx_def;
  logic       busy_8n1, busy_8e1, busy_8o1, busy_7n2, busy_def;

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .wr(if_8n1), .tx_enable_i(en_main),
    .fifo_count_o(cnt_8n1), .tx_busy_o(busy_8n1), .uart_tx_o(tx_8n1));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8e1 (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .wr(if_8e1), .tx_enable_i(en_on),
    .fifo_count_o(cnt_8e1), .tx_busy_o(busy_8e1), .uart_tx_o(tx_8e1));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .wr(if_8o1), .tx_enable_i(en_on),
    .fifo_count_o(cnt_8o1), .tx_busy_o(busy_8o1), .uart_tx_o(tx_8o1));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .wr(if_7n2), .tx_enable_i(en_on),
    .fifo_count_o(cnt_7n2), .tx_busy_o(busy_7n2), .uart_tx_o(tx_7n2));
  uart_tx_fifo #(.FIFO_DEPTH(4)) u_def (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .wr(if_def), .tx_enable_i(en_on),
    .fifo_count_o(cnt_def), .tx_busy_o(busy_def), .uart_tx_o(tx_def));

  logic [4:0] tx_v, busy_v, ready_v;
  assign tx_v    = {tx_def, tx_7n2, tx_8o1, tx_8e1, tx_8n1};
  assign busy_v  = {busy_def, busy_7n2, busy_8o1, busy_8e1, busy_8n1};
  assign ready_v = {if_def.tx_ready_o, if_7n2.tx_ready_o, if_8o1.tx_ready_o,
                    if_8e1.tx_ready_o, if_8n1.tx_ready_o};

  int nb_cfg   [5] = '{8, 8, 8, 7, 8};
  int par_cfg  [5] = '{0, 2, 1, 0, 0};
  int stop_cfg [5] = '{1, 1, 1, 2, 1};

  frame_t sb[$];
  int     edge_t[$];
  int     n_assert = 0;
  int     n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, payload LSB first, optional parity, stop bits at 1.
  function automatic frame_t model_frame(input logic [7:0] data, input int nb, input int par,
                                         input int stops);
    frame_t f;
    int     k;
    logic   p;
    f.bits = '0;
    p      = 1'b0;
    k      = 1;
    for (int i = 0; i < nb; i++) begin
      f.bits[k] = data[i];
      p         = p ^ data[i];
      k++;
    end
    if (par != 0) begin
      f.bits[k] = (par == 2) ? p : ~p;
      k++;
    end
    for (int i = 0; i < stops; i++) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.len = k;
    return f;
  endfunction

  task automatic drive(input int which, input logic v, input logic [7:0] data);
    case (which)
      0: begin if_8n1.tx_valid_i = v; if_8n1.tx_data_i = data;      end
      1: begin if_8e1.tx_valid_i = v; if_8e1.tx_data_i = data;      end
      2: begin if_8o1.tx_valid_i = v; if_8o1.tx_data_i = data;      end
      3: begin if_7n2.tx_valid_i = v; if_7n2.tx_data_i = data[6:0]; end
      default: begin if_def.tx_valid_i = v; if_def.tx_data_i = data; end
    endcase
  endtask

  // One-cycle write; returns at the falling edge after the accepting clock edge.
  task automatic push(input int which, input logic [7:0] data, output bit acc);
    @(negedge clk);
    drive(which, 1'b1, data);
    acc = ready_v[which];
    if (acc && which != 4)
      sb.push_back(model_frame(data, nb_cfg[which], par_cfg[which], stop_cfg[which]));
    @(posedge clk);
    @(negedge clk);
    drive(which, 1'b0, 8'h00);
  endtask

  // Pops the next expected frame and checks line and busy on every cycle of it.
  // The start bit must appear within max_wait falling edges of the current one.
  task automatic check_frame(input int which, input int max_wait, input string tag);
    frame_t f;
    bit     found;
    check({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    f     = sb.pop_front();
    found = 1'b0;
    for (int w = 0; w <= max_wait; w++) begin
      if (tx_v[which] === 1'b0) begin
        found = 1'b1;
        break;
      end
      if (w < max_wait) @(negedge clk);
    end
    check({tag, " start_seen"}, 32'(found), 32'd1);
    if (!found) return;
    for (int c = 0; c < f.len * 16; c++) begin
      check($sformatf("%s line c%0d", tag, c), 32'(tx_v[which]), 32'(f.bits[c / 16]));
      check($sformatf("%s busy c%0d", tag, c), 32'(busy_v[which]), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          acc;
    logic [7:0]  tdata [1:3];
    logic        prev;
    int          end_t;
    real         nominal, diff;

    tdata[1] = 8'h07;
    tdata[2] = 8'h07;
    tdata[3] = 8'h7F;
    rst_n   = 1'b0;
    en_main = 1'b1;
    en_on   = 1'b1;
    for (int w = 0; w < 5; w++) drive(w, 1'b0, 8'h00);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_line",  32'(tx_v),    32'h1f);
    check("rst_busy",  32'(busy_v),  32'h00);
    check("rst_ready", 32'(ready_v), 32'h1f);
    check("rst_count", 32'(cnt_8n1), 32'd0);
    rst_n = 1'b1;

    // 8N1 frame of 0xA5 with two-cycle write-to-start latency
    push(0, 8'hA5, acc);
    check("t1_acc", 32'(acc), 32'd1);
    check("t1_line_n1", 32'(tx_8n1), 32'd1);
    check("t1_busy_n1", 32'(busy_8n1), 32'd0);
    @(negedge clk);
    check_frame(0, 0, "t1");
    check("t1_idle_busy", 32'(busy_8n1), 32'd0);
    check("t1_idle_line", 32'(tx_8n1), 32'd1);

    // Parity and two-stop-bit variants
    for (int w = 1; w <= 3; w++) begin
      push(w, tdata[w], acc);
      check($sformatf("t2_acc%0d", w), 32'(acc), 32'd1);
      check($sformatf("t2_line_n1_%0d", w), 32'(tx_v[w]), 32'd1);
      @(negedge clk);
      check_frame(w, 0, $sformatf("t2_cfg%0d", w));
      check($sformatf("t2_idle_busy%0d", w), 32'(busy_v[w]), 32'd0);
    end

    // Fill with transmission disabled; the 17th write is refused
    en_main = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(0, 8'(8'h30 + i * 7), acc);
      check($sformatf("t3_acc%0d", i), 32'(acc), 32'(i < 16));
    end
    check("t3_ready_full", 32'(if_8n1.tx_ready_o), 32'd0);
    check("t3_count_full", 32'(cnt_8n1), 32'd16);
    check("t3_busy_off",   32'(busy_8n1), 32'd0);

    // Push on full in the same cycle as the first pop: refused, count 16 -> 15
    drive(0, 1'b1, 8'hEE);
    en_main = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    check("t4_count", 32'(cnt_8n1), 32'd15);
    check("t4_ready", 32'(if_8n1.tx_ready_o), 32'd1);
    for (int i = 0; i < 16; i++) check_frame(0, 0, $sformatf("t3_b2b%0d", i));
    check("t3_end_busy",  32'(busy_8n1), 32'd0);
    check("t3_end_count", 32'(cnt_8n1), 32'd0);
    check("t3_sb_empty",  32'(sb.size()), 32'd0);

    // Reset 40 cycles into a frame with one word still queued
    push(0, 8'h3C, acc);
    push(0, 8'h11, acc);
    repeat (39) @(negedge clk);
    check("t5_pre_busy",  32'(busy_8n1), 32'd1);
    check("t5_pre_count", 32'(cnt_8n1), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_line",  32'(tx_8n1), 32'd1);
    check("t5_busy",  32'(busy_8n1), 32'd0);
    check("t5_count", 32'(cnt_8n1), 32'd0);
    check("t5_ready", 32'(if_8n1.tx_ready_o), 32'd1);
    rst_n = 1'b1;
    sb.delete();
    push(0, 8'h96, acc);
    check("t5_acc", 32'(acc), 32'd1);
    check("t5_line_n1", 32'(tx_8n1), 32'd1);
    @(negedge clk);
    check_frame(0, 0, "t5_clean");
    check("t5_end_busy", 32'(busy_8n1), 32'd0);

    // Default 10 MHz / 115200: every edge within one cycle of k*CLK_HZ/BAUD
    push(4, 8'h55, acc);
    check("t6_acc", 32'(acc), 32'd1);
    @(negedge clk);
    check("t6_start", 32'(tx_def), 32'd0);
    prev  = 1'b0;
    end_t = 0;
    for (int c = 1; c <= 1200; c++) begin
      @(negedge clk);
      if (busy_def === 1'b0) begin
        end_t = c;
        break;
      end
      if (tx_def !== prev) begin
        prev = tx_def;
        edge_t.push_back(c);
      end
    end
    check("t6_edges", 32'(edge_t.size()), 32'd9);
    for (int k = 1; k <= 9 && k <= edge_t.size(); k++) begin
      nominal = k * 10000000.0 / 115200.0;
      diff    = $itor(edge_t[k-1]) - nominal;
      check($sformatf("t6_edge%0d t=%0d", k, edge_t[k-1]), 32'(diff >= -1.0 && diff <= 1.0), 32'd1);
    end
    nominal = 10 * 10000000.0 / 115200.0;
    diff    = $itor(end_t) - nominal;
    check($sformatf("t6_frame_end t=%0d", end_t), 32'(diff >= -1.0 && diff <= 1.0), 32'd1);
    check("t6_idle_line", 32'(tx_def), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
